// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_ctrl_pkg
// Description : Shared types and helpers for the digital-clock timing and
//               mode controller: FSM state encoding, counter-width helper
//               and the mode-advance function.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_ctrl_pkg;

    // Encoding is visible on the mode LEDs: 0=RUN 1=SET_HOUR 2=SET_MIN.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_e;

    // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Mode button walks RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic state_e next_mode(input state_e s);
        case (s)
            ST_RUN:      return ST_SET_HOUR;
            ST_SET_HOUR: return ST_SET_MIN;
            default:     return ST_RUN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_ctrl_btn_cond.sv
`default_nettype none
// ============================================================================
// Module      : clock_ctrl_btn_cond
// Description : Push-button conditioner: 2-flop synchronizer, debounce filter
//               and accepted-rising-edge pulse.
// Ports       : clk_i   - system clock
//               rst_i   - synchronous active-high reset
//               btn_i   - raw button level, asynchronous to clk_i
//               press_o - one-cycle pulse when a 0->1 change is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module clock_ctrl_btn_cond
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int              c_cnt_w    = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               sync1_q;
    logic               sync2_q;
    logic               level_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic               w_differ;
    logic               w_accept;

    // cnt_q holds how many earlier consecutive samples already differed from
    // the accepted level, so the current differing sample completes the run.
    assign w_differ = sync2_q ^ level_q;
    assign w_accept = w_differ && (cnt_q == c_cnt_last);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if (!w_differ) begin
                cnt_q <= '0;
            end else if (w_accept) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + c_cnt_one;
            end
        end
    end

    // Only the accepted press edge is reported; releases are silent.
    assign press_o = w_accept & sync2_q;

endmodule
`default_nettype wire

// File: rtl/clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_ctrl
// Description : Timing and mode controller for the digital clock. Generates
//               the second tick, cascades it into minute/hour enables, runs
//               the RUN/SET_HOUR/SET_MIN mode FSM and blinks the field being
//               set.
// Ports       : clk_i        - system clock
//               glob_rst_i   - synchronous active-high reset
//               btn_mode_i   - raw mode button
//               btn_inc_i    - raw increment button
//               sec_tc_i     - seconds stage at terminal count
//               min_tc_i     - minutes stage at terminal count
//               ce_sec_o     - enable to seconds stage
//               ce_min_o     - enable to minutes stage
//               ce_hour_o    - enable to hours stage
//               blank_min_o  - blank minute digits
//               blank_hour_o - blank hour digits
//               mode_o       - current mode for LEDs
// Revision    : 1.0 - initial release
// ============================================================================
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_DIV       = 12_500_000
) (
    input  logic       clk_i,
    input  logic       glob_rst_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       sec_tc_i,
    input  logic       min_tc_i,
    output logic       ce_sec_o,
    output logic       ce_min_o,
    output logic       ce_hour_o,
    output logic       blank_min_o,
    output logic       blank_hour_o,
    output logic [1:0] mode_o
);

    localparam int                 c_div_w      = ctr_width(TICK_DIV);
    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(TICK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one    = c_div_w'(1);
    localparam int                 c_blk_w      = ctr_width(BLINK_DIV);
    localparam logic [c_blk_w-1:0] c_blk_last   = c_blk_w'(BLINK_DIV - 1);
    localparam logic [c_blk_w-1:0] c_blk_one    = c_blk_w'(1);

    logic [c_div_w-1:0] div_cnt_q;
    logic [c_blk_w-1:0] blink_cnt_q;
    logic               blink_ph_q;
    state_e             state_q;

    logic w_tick;
    logic w_mode_press;
    logic w_inc_press;
    logic w_inc_ok;
    logic w_run;
    logic w_set_hour;
    logic w_set_min;

    // ------------------------------------------------------------------
    // Second tick divider, free-running in every mode.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (glob_rst_i) begin
            div_cnt_q <= '0;
        end else if (div_cnt_q == c_div_last) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + c_div_one;
        end
    end

    assign w_tick = (div_cnt_q == c_div_last);

    // ------------------------------------------------------------------
    // Button conditioning.
    // ------------------------------------------------------------------
    clock_ctrl_btn_cond #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_mode (
        .clk_i   (clk_i),
        .rst_i   (glob_rst_i),
        .btn_i   (btn_mode_i),
        .press_o (w_mode_press)
    );

    clock_ctrl_btn_cond #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_inc (
        .clk_i   (clk_i),
        .rst_i   (glob_rst_i),
        .btn_i   (btn_inc_i),
        .press_o (w_inc_press)
    );

    // ------------------------------------------------------------------
    // Mode FSM with blink generator. A mode press restarts the blink so
    // the newly selected field starts visible; an increment forces the
    // phase visible without disturbing the half-period counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (glob_rst_i) begin
            state_q     <= ST_RUN;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (w_mode_press) begin
            state_q     <= next_mode(state_q);
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            if (blink_cnt_q == c_blk_last) begin
                blink_cnt_q <= '0;
                blink_ph_q  <= ~blink_ph_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + c_blk_one;
            end
            // Placed last so it overrides a coincident phase toggle.
            if (w_inc_press && (state_q != ST_RUN)) begin
                blink_ph_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Enables and blanking, decoded from registered state.
    // ------------------------------------------------------------------
    assign w_run      = (state_q == ST_RUN);
    assign w_set_hour = (state_q == ST_SET_HOUR);
    assign w_set_min  = (state_q == ST_SET_MIN);

    // An increment coinciding with a mode change is dropped.
    assign w_inc_ok   = w_inc_press & ~w_mode_press;

    assign ce_sec_o     = w_run & w_tick;
    assign ce_min_o     = (w_run & w_tick & sec_tc_i) | (w_set_min & w_inc_ok);
    assign ce_hour_o    = (w_run & w_tick & sec_tc_i & min_tc_i) | (w_set_hour & w_inc_ok);
    assign blank_hour_o = w_set_hour & blink_ph_q;
    assign blank_min_o  = w_set_min & blink_ph_q;
    assign mode_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_ctrl
// Description : Self-checking bench for clock_ctrl with small dividers.
//               A window-based behavioural model checks every cycle; table
//               vectors and hand sequences cover the cascade and corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_ctrl;

    localparam int TICK = 10;
    localparam int DEB  = 4;
    localparam int BLK  = 5;

    logic       clk = 1'b0;
    logic       glob_rst, btn_mode, btn_inc, sec_tc, min_tc;
    logic       ce_sec, ce_min, ce_hour, blank_min, blank_hour;
    logic [1:0] mode;

    always #5 clk = ~clk;

    clock_ctrl #(
        .TICK_DIV        (TICK),
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_DIV       (BLK)
    ) dut (
        .clk_i        (clk),
        .glob_rst_i   (glob_rst),
        .btn_mode_i   (btn_mode),
        .btn_inc_i    (btn_inc),
        .sec_tc_i     (sec_tc),
        .min_tc_i     (min_tc),
        .ce_sec_o     (ce_sec),
        .ce_min_o     (ce_min),
        .ce_hour_o    (ce_hour),
        .blank_min_o  (blank_min),
        .blank_hour_o (blank_hour),
        .mode_o       (mode)
    );

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    // Model state: cycles since reset, mode, raw-input history per button,
    // accepted levels, SET-entry cycle and blink base cycle.
    int   t, cyc, m_mode, entry, base;
    bit   hm[$];
    bit   hi[$];
    bit   acc_m, acc_i;

    // Last observed outputs: {ce_sec, ce_min, ce_hour, blank_min, blank_hour, mode[1:0]}
    logic [6:0] obs;
    int         obs_cyc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, obs_cyc, act, exp);
        end
    endtask

    // The debouncer accepts a new level once the input, seen through the
    // two synchronizer stages, has differed from the accepted level for DEB
    // consecutive cycles. History holds raw inputs of cycles c-DEB-1 .. c.
    function automatic bit window_hit(input bit q[$], input bit acc);
        for (int k = 0; k < DEB; k++) begin
            if (q[k] == acc) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        t      = 0;
        m_mode = 0;
        acc_m  = 1'b0;
        acc_i  = 1'b0;
        hm.delete();
        hi.delete();
        for (int k = 0; k < DEB + 1; k++) begin
            hm.push_back(1'b0);
            hi.push_back(1'b0);
        end
    endtask

    // One clock cycle: inputs are already driven; predict, sample, advance.
    task automatic step();
        bit         mchg, ichg, mp, ip, tk;
        int         ph;
        logic [6:0] exp;
        hm.push_back(btn_mode);
        hi.push_back(btn_inc);
        while (hm.size() > DEB + 2) void'(hm.pop_front());
        while (hi.size() > DEB + 2) void'(hi.pop_front());
        mchg = window_hit(hm, acc_m);
        ichg = window_hit(hi, acc_i);
        mp   = mchg && !acc_m;
        ip   = ichg && !acc_i;
        tk   = (t % TICK) == TICK - 1;
        ph   = (((cyc - entry) / BLK) - ((base - entry) / BLK)) % 2;
        exp[6]   = (m_mode == 0) && tk;
        exp[5]   = ((m_mode == 0) && tk && sec_tc) || ((m_mode == 2) && ip && !mp);
        exp[4]   = ((m_mode == 0) && tk && sec_tc && min_tc) || ((m_mode == 1) && ip && !mp);
        exp[3]   = (m_mode == 2) && (ph == 1);
        exp[2]   = (m_mode == 1) && (ph == 1);
        exp[1:0] = m_mode[1:0];
        #4;
        obs     = {ce_sec, ce_min, ce_hour, blank_min, blank_hour, mode};
        obs_cyc = cyc;
        check(phase, {25'd0, obs}, {25'd0, exp});
        if (glob_rst) begin
            model_reset();
        end else begin
            t++;
            if (mchg) acc_m = ~acc_m;
            if (ichg) acc_i = ~acc_i;
            if (mp) begin
                m_mode = (m_mode + 1) % 3;
                entry  = cyc + 1;
                base   = cyc + 1;
            end else if (ip && m_mode != 0) begin
                base = cyc + 1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Hold a button pattern: high for hi_n cycles then low for lo_n cycles.
    task automatic pulse(input bit do_mode, input bit do_inc, input int hi_n, input int lo_n,
                         output int n_min, output int n_hour, output int n_sec);
        n_min = 0; n_hour = 0; n_sec = 0;
        for (int k = 0; k < hi_n + lo_n; k++) begin
            if (do_mode) btn_mode = (k < hi_n);
            if (do_inc)  btn_inc  = (k < hi_n);
            step();
            n_sec  += int'(obs[6]);
            n_min  += int'(obs[5]);
            n_hour += int'(obs[4]);
        end
    endtask

    typedef struct {
        bit s_tc;
        bit m_tc;
        bit e_min;
        bit e_hour;
    } tv_t;

    initial begin
        tv_t tv[4];
        int  first, cnt, seen, prev, last_edge, gaps_bad, edges;
        int  nm, nh, ns, sm, sh, ss, hold_m, hold_i;

        tv[0] = '{1'b1, 1'b1, 1'b1, 1'b1};
        tv[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b0, 1'b0, 1'b0};

        glob_rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; sec_tc = 1'b0; min_tc = 1'b0;
        cyc = 0; entry = 0; base = 0; obs_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        glob_rst = 1'b0;

        // 1: idle tick spacing
        phase = "idle";
        first = -1; cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (k == 0) check("reset_outputs", {25'd0, obs}, 32'd0);
            if (obs[6]) begin
                cnt++;
                if (first < 0) first = obs_cyc;
            end
            if (obs[5] || obs[4]) check("idle_no_cascade", {30'd0, obs[5:4]}, 32'd0);
        end
        check("first_tick_cycle", first, 9);
        check("tick_count_30", cnt, 3);

        // 2: cascade table applied at tick cycles
        phase = "cascade";
        for (int v = 0; v < 4; v++) begin
            sec_tc = tv[v].s_tc;
            min_tc = tv[v].m_tc;
            while ((t % TICK) != TICK - 1) step();
            step();
            check("tv_ce_sec",  {31'd0, obs[6]}, 32'd1);
            check("tv_ce_min",  {31'd0, obs[5]}, {31'd0, tv[v].e_min});
            check("tv_ce_hour", {31'd0, obs[4]}, {31'd0, tv[v].e_hour});
        end
        sec_tc = 1'b0; min_tc = 1'b0;

        // 3: bounce rejected, then held press latency
        phase = "mode_btn";
        pulse(1'b1, 1'b0, 3, 10, nm, nh, ns);
        check("bounce_rejected_mode", {30'd0, obs[1:0]}, 32'd0);
        seen = -1;
        for (int k = 0; k < 14; k++) begin
            btn_mode = (k < 10);
            step();
            if (seen < 0 && obs[1:0] == 2'd1) seen = k;
        end
        check("mode_latency", seen, 6);

        // 4: SET_HOUR blink cadence and increments
        phase = "set_hour";
        prev = int'(obs[2]); last_edge = -1; gaps_bad = 0; edges = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (int'(obs[2]) != prev) begin
                if (last_edge >= 0 && (obs_cyc - last_edge) != BLK) gaps_bad++;
                last_edge = obs_cyc;
                edges++;
            end
            prev = int'(obs[2]);
        end
        check("blink_gap_errors", gaps_bad, 0);
        check("blink_edges_ge3", {31'd0, edges >= 3}, 32'd1);
        sh = 0; ss = 0;
        for (int p = 0; p < 3; p++) begin
            pulse(1'b0, 1'b1, 6, 6, nm, nh, ns);
            sh += nh; ss += ns;
        end
        pulse(1'b0, 1'b0, 0, 14, nm, nh, ns);
        sh += nh; ss += ns;
        check("set_hour_ce_hour", sh, 3);
        check("set_hour_ce_sec", ss, 0);

        // 5: SET_MIN increment, then simultaneous mode+inc
        phase = "set_min";
        pulse(1'b1, 1'b0, 6, 6, nm, nh, ns);
        check("enter_set_min", {30'd0, obs[1:0]}, 32'd2);
        sec_tc = 1'b1; min_tc = 1'b1;
        pulse(1'b0, 1'b1, 6, 6, nm, nh, ns);
        check("set_min_ce_min", nm, 1);
        check("set_min_ce_hour", nh, 0);
        sec_tc = 1'b0;
        pulse(1'b1, 1'b1, 7, 7, nm, nh, ns);
        check("simul_mode", {30'd0, obs[1:0]}, 32'd0);
        check("simul_no_ce", nm + nh, 0);
        min_tc = 1'b0;

        // 6: reset mid-debounce in SET_MIN
        phase = "reset_mid";
        pulse(1'b1, 1'b0, 6, 6, nm, nh, ns);
        pulse(1'b1, 1'b0, 6, 6, nm, nh, ns);
        check("reenter_set_min", {30'd0, obs[1:0]}, 32'd2);
        btn_inc = 1'b1;
        repeat (3) step();
        glob_rst = 1'b1; btn_inc = 1'b0;
        step();
        glob_rst = 1'b0;
        step();
        check("post_reset_outputs", {25'd0, obs}, 32'd0);
        sm = 0; sh = 0; seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            sm += int'(obs[5]); sh += int'(obs[4]);
            if (obs[1:0] != 2'd0) seen++;
        end
        check("no_stale_press", sm + sh, 0);
        check("stay_run", seen, 0);

        // Random stimulus against the model
        phase = "random";
        hold_m = 0; hold_i = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold_m == 0) begin btn_mode = 1'($urandom_range(0, 1)); hold_m = $urandom_range(1, 9); end
            if (hold_i == 0) begin btn_inc  = 1'($urandom_range(0, 1)); hold_i = $urandom_range(1, 9); end
            hold_m--; hold_i--;
            sec_tc   = 1'($urandom_range(0, 1));
            min_tc   = 1'($urandom_range(0, 1));
            glob_rst = ($urandom_range(0, 399) == 0);
            step();
        end
        glob_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
